// File: rtl/spi_arb.sv
// spi_arb: round-robin sequencer sharing one SPI master between NUM_REQ requesters.
// Define SPI_ARB_TIMEOUT_EN to add a WAIT-state watchdog that sets the sticky to_err flag.
module spi_arb #(
   parameter int NUM_REQ = 2,
   parameter int GAP_CYC = 4,
   parameter int TO_CYC  = 65535
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic [NUM_REQ-1:0]    req,
   input  logic [16*NUM_REQ-1:0] req_cmd,
   output logic [NUM_REQ-1:0]    gnt,
   output logic [NUM_REQ-1:0]    rsp_vld,
   output logic [15:0]           rsp_data,
   output logic                  busy,
   output logic                  spi_wrt,
   output logic [15:0]           spi_cmd,
   input  logic                  spi_done,
   input  logic [15:0]           spi_rd_data,
   output logic                  to_err
);
   localparam int IDX_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

   typedef enum logic [1:0] {IDLE, LAUNCH, WAIT, GAP} state_t;

   state_t               state_q, state_d;
   logic [IDX_W-1:0]     owner_q, owner_d;
   logic [IDX_W-1:0]     ptr_q, ptr_d;
   logic [IDX_W-1:0]     win, sel;
   logic                 found;
   logic [NUM_REQ-1:0]   gnt_q, gnt_d;
   logic [NUM_REQ-1:0]   rsp_vld_q, rsp_vld_d;
   logic [15:0]          rsp_data_q, rsp_data_d;
   logic [15:0]          spi_cmd_q, spi_cmd_d;
   logic [15:0]          win_cmd;
   logic                 busy_q, busy_d;
   logic                 wrt_q, wrt_d;
   logic [7:0]           gap_q, gap_d;
   logic                 to_evt;

`ifdef SPI_ARB_TIMEOUT_EN
   logic [15:0] to_cnt_q, to_cnt_d;
   logic        to_err_q, to_err_d;

   assign to_evt = (state_q == WAIT) && !spi_done && (to_cnt_q == 16'(TO_CYC - 1));

   always_comb begin
      to_cnt_d = (state_q == WAIT) ? to_cnt_q + 16'd1 : 16'd0;
      to_err_d = to_err_q | to_evt;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         to_cnt_q <= 16'd0;
         to_err_q <= 1'b0;
      end else begin
         to_cnt_q <= to_cnt_d;
         to_err_q <= to_err_d;
      end
   end

   assign to_err = to_err_q;
`else
   assign to_evt = 1'b0;
   assign to_err = 1'b0;
`endif

   // Search starts at ptr and wraps, so the last winner becomes lowest priority.
   always_comb begin
      found   = 1'b0;
      win     = ptr_q;
      sel     = ptr_q;
      win_cmd = 16'h0000;
      for (int i = 0; i < NUM_REQ; i++) begin
         sel = IDX_W'((int'(ptr_q) + i) % NUM_REQ);
         if (!found && req[sel]) begin
            found = 1'b1;
            win   = sel;
         end
      end
      for (int i = 0; i < NUM_REQ; i++) begin
         if (win == IDX_W'(i)) begin
            win_cmd = req_cmd[16*i +: 16];
         end
      end
   end

   always_comb begin
      state_d    = state_q;
      owner_d    = owner_q;
      ptr_d      = ptr_q;
      gnt_d      = '0;
      rsp_vld_d  = '0;
      rsp_data_d = rsp_data_q;
      spi_cmd_d  = spi_cmd_q;
      busy_d     = busy_q;
      wrt_d      = 1'b0;
      gap_d      = gap_q;
      case (state_q)
         IDLE: begin
            if (found) begin
               spi_cmd_d = win_cmd;
               owner_d   = win;
               ptr_d     = IDX_W'((int'(win) + 1) % NUM_REQ);
               gnt_d     = NUM_REQ'(1) << win;
               wrt_d     = 1'b1;
               busy_d    = 1'b1;
               state_d   = LAUNCH;
            end
         end
         LAUNCH: state_d = WAIT;
         WAIT: begin
            if (spi_done || to_evt) begin
               rsp_data_d = spi_done ? spi_rd_data : 16'hDEAD;
               rsp_vld_d  = NUM_REQ'(1) << owner_q;
               gap_d      = 8'(GAP_CYC);
               state_d    = GAP;
            end
         end
         GAP: begin
            gap_d = gap_q - 8'd1;
            if (gap_q <= 8'd1) begin
               gap_d   = 8'd0;
               busy_d  = 1'b0;
               state_d = IDLE;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q    <= IDLE;
         owner_q    <= '0;
         ptr_q      <= '0;
         gnt_q      <= '0;
         rsp_vld_q  <= '0;
         rsp_data_q <= 16'h0000;
         spi_cmd_q  <= 16'h0000;
         busy_q     <= 1'b0;
         wrt_q      <= 1'b0;
         gap_q      <= 8'd0;
      end else begin
         state_q    <= state_d;
         owner_q    <= owner_d;
         ptr_q      <= ptr_d;
         gnt_q      <= gnt_d;
         rsp_vld_q  <= rsp_vld_d;
         rsp_data_q <= rsp_data_d;
         spi_cmd_q  <= spi_cmd_d;
         busy_q     <= busy_d;
         wrt_q      <= wrt_d;
         gap_q      <= gap_d;
      end
   end

   assign gnt      = gnt_q;
   assign rsp_vld  = rsp_vld_q;
   assign rsp_data = rsp_data_q;
   assign busy     = busy_q;
   assign spi_wrt  = wrt_q;
   assign spi_cmd  = spi_cmd_q;

endmodule

// File: tb/tb_spi_arb.sv
// tb_spi_arb: table-driven and scoreboard checks for spi_arb with a simple SPI slave model.
// Build with SPI_ARB_TIMEOUT_EN defined to also exercise the timeout path.
module tb_spi_arb;
   localparam int NUM_REQ   = 2;
   localparam int GAP_CYC   = 4;
   localparam int TO_CYC    = 100;
   localparam int SLAVE_LAT = 3;

   typedef struct {
      int          idx;
      logic [15:0] cmd;
      logic [15:0] rdata;
   } txn_t;

   logic                  clk = 1'b0;
   logic                  rst = 1'b1;
   logic [NUM_REQ-1:0]    req = '0;
   logic [16*NUM_REQ-1:0] req_cmd = '0;
   logic [NUM_REQ-1:0]    gnt;
   logic [NUM_REQ-1:0]    rsp_vld;
   logic [15:0]           rsp_data;
   logic                  busy;
   logic                  spi_wrt;
   logic [15:0]           spi_cmd;
   logic                  spi_done;
   logic [15:0]           spi_rd_data = 16'h0000;
   logic                  to_err;

   int n_checks = 0;
   int n_err    = 0;

   spi_arb #(.NUM_REQ(NUM_REQ), .GAP_CYC(GAP_CYC), .TO_CYC(TO_CYC)) dut (
      .clk(clk), .rst(rst), .req(req), .req_cmd(req_cmd), .gnt(gnt),
      .rsp_vld(rsp_vld), .rsp_data(rsp_data), .busy(busy), .spi_wrt(spi_wrt),
      .spi_cmd(spi_cmd), .spi_done(spi_done), .spi_rd_data(spi_rd_data), .to_err(to_err)
   );

   always #5 clk = ~clk;

   task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_err++;
         $display("[TB] FAIL %s: got %h, expected %h", name, act, exp);
      end
   endtask

   function automatic logic [15:0] slaveResp(input logic [15:0] c);
      return (c == 16'h63AC) ? 16'h1234 : ({c[7:0], c[15:8]} ^ 16'h3C3C);
   endfunction

   // Slave model: answers each launch after SLAVE_LAT cycles with a one-cycle done.
   int          slave_cnt = 0;
   bit          slave_en = 1'b1;
   logic        slave_done = 1'b0;
   logic        stray_done = 1'b0;
   logic [15:0] slave_cmd = 16'h0000;

   assign spi_done = slave_done | stray_done;

   always @(negedge clk) begin
      slave_done = 1'b0;
      if (rst) begin
         slave_cnt = 0;
      end else if (spi_wrt && slave_en) begin
         slave_cnt = SLAVE_LAT;
         slave_cmd = spi_cmd;
      end else if (slave_cnt > 0) begin
         slave_cnt--;
         if (slave_cnt == 0) begin
            slave_done  = 1'b1;
            spi_rd_data = slaveResp(slave_cmd);
         end
      end
   end

   // Scoreboard: expected transactions are queued by the stimulus and retired on gnt/rsp_vld.
   txn_t exp_q[$];
   txn_t cur;
   bit   cur_valid = 1'b0;
   bit   have_rsp = 1'b0;
   int   cyc = 0;
   int   rsp_cyc = 0;

   always @(negedge clk) begin
      cyc++;
      if (rst) begin
         exp_q.delete();
         cur_valid = 1'b0;
         have_rsp  = 1'b0;
      end else begin
         if (gnt != '0) begin
            if (exp_q.size() == 0) begin
               checkOutput("unexpected_gnt", 32'(gnt), 32'd0);
            end else begin
               cur       = exp_q.pop_front();
               cur_valid = 1'b1;
               checkOutput("gnt_onehot", 32'(gnt), 32'(1) << cur.idx);
               checkOutput("wrt_with_gnt", 32'(spi_wrt), 32'd1);
               checkOutput("spi_cmd", 32'(spi_cmd), 32'(cur.cmd));
               if (have_rsp) checkOutput("gap_respected", 32'((cyc - rsp_cyc) >= GAP_CYC), 32'd1);
            end
         end else if (spi_wrt) begin
            checkOutput("wrt_without_gnt", 32'(spi_wrt), 32'd0);
         end
         if (rsp_vld != '0) begin
            rsp_cyc  = cyc;
            have_rsp = 1'b1;
            if (!cur_valid) begin
               checkOutput("unexpected_rsp", 32'(rsp_vld), 32'd0);
            end else begin
               checkOutput("rsp_vld_owner", 32'(rsp_vld), 32'(1) << cur.idx);
               checkOutput("rsp_data", 32'(rsp_data), 32'(cur.rdata));
               cur_valid = 1'b0;
            end
         end
`ifndef SPI_ARB_TIMEOUT_EN
         if (to_err) checkOutput("to_err_tied_low", 32'(to_err), 32'd0);
`endif
      end
   end

   // kind 0: any gnt, 1: any rsp_vld, 2: arbiter idle with scoreboard drained
   task automatic waitSig(input string name, input int kind, input int limit);
      bit seen = 1'b0;
      for (int i = 0; i < limit && !seen; i++) begin
         @(negedge clk);
         case (kind)
            0:       seen = (gnt != '0);
            1:       seen = (rsp_vld != '0);
            default: seen = !busy && !cur_valid && (exp_q.size() == 0);
         endcase
      end
      if (!seen) begin
         n_checks++;
         n_err++;
         $display("[TB] FAIL %s_timeout: no event within %0d cycles", name, limit);
      end
   endtask

   task automatic applyStimulus(input txn_t t);
      exp_q.push_back(t);
      req_cmd[16*t.idx +: 16] = t.cmd;
      req[t.idx] = 1'b1;
      waitSig("gnt", 0, 20);
      req[t.idx] = 1'b0;
   endtask

   task automatic checkReset();
      checkOutput("rst_gnt", 32'(gnt), 32'd0);
      checkOutput("rst_rsp_vld", 32'(rsp_vld), 32'd0);
      checkOutput("rst_spi_wrt", 32'(spi_wrt), 32'd0);
      checkOutput("rst_busy", 32'(busy), 32'd0);
      checkOutput("rst_spi_cmd", 32'(spi_cmd), 32'd0);
      checkOutput("rst_rsp_data", 32'(rsp_data), 32'd0);
      checkOutput("rst_to_err", 32'(to_err), 32'd0);
   endtask

   initial begin
      txn_t vec[5];
      vec[0] = '{0, 16'h63AC, 16'h1234};
      vec[1] = '{1, 16'hA5A5, 16'h9999};
      vec[2] = '{1, 16'h0000, 16'h3C3C};
      vec[3] = '{0, 16'hFFFF, 16'hC3C3};
      vec[4] = '{0, 16'h1200, 16'h3C2E};

      $display("[TB] reset and idle");
      repeat (3) @(negedge clk);
      checkReset();
      rst = 1'b0;
      for (int i = 0; i < 10; i++) begin
         @(negedge clk);
         checkOutput("idle_no_wrt", 32'(spi_wrt), 32'd0);
         checkOutput("idle_not_busy", 32'(busy), 32'd0);
      end

      $display("[TB] single-request table");
      for (int i = 0; i < 5; i++) begin
         applyStimulus(vec[i]);
         waitSig("rsp", 1, 20);
         checkOutput("busy_at_rsp", 32'(busy), 32'd1);
         waitSig("drain", 2, 20);
      end

      $display("[TB] late request during gap");
      applyStimulus('{0, 16'h4321, slaveResp(16'h4321)});
      waitSig("rsp", 1, 20);
      exp_q.push_back('{1, 16'h0F0F, slaveResp(16'h0F0F)});
      req_cmd[31:16] = 16'h0F0F;
      req[1] = 1'b1;
      for (int i = 0; i < GAP_CYC; i++) begin
         if (i > 0) @(negedge clk);
         checkOutput("gap_busy", 32'(busy), 32'd1);
         checkOutput("gap_no_gnt", 32'(gnt), 32'd0);
      end
      waitSig("late_gnt", 0, 6);
      req[1] = 1'b0;
      waitSig("drain", 2, 30);

      $display("[TB] reset mid-wait");
      slave_en = 1'b0;
      applyStimulus('{0, 16'hBEEF, 16'h0000});
      repeat (3) @(negedge clk);
      rst = 1'b1;
      repeat (2) @(negedge clk);
      checkReset();
      rst = 1'b0;
      @(negedge clk);
      stray_done = 1'b1;
      @(negedge clk);
      stray_done = 1'b0;
      slave_en   = 1'b1;
      for (int i = 0; i < 10; i++) begin
         @(negedge clk);
         checkOutput("post_rst_no_wrt", 32'(spi_wrt), 32'd0);
         checkOutput("post_rst_no_rsp", 32'(rsp_vld), 32'd0);
         checkOutput("post_rst_not_busy", 32'(busy), 32'd0);
      end

      $display("[TB] contention");
      for (int i = 0; i < 2; i++) begin
         exp_q.push_back('{0, 16'hA5A5, 16'h9999});
         exp_q.push_back('{1, 16'h5A5A, 16'h6666});
      end
      req_cmd = {16'h5A5A, 16'hA5A5};
      req     = 2'b11;
      for (int i = 0; i < 4; i++) waitSig("contend_gnt", 0, 40);
      req = 2'b00;
      waitSig("drain", 2, 40);

`ifdef SPI_ARB_TIMEOUT_EN
      $display("[TB] timeout");
      begin
         int k;
         k = 0;
         slave_en = 1'b0;
         applyStimulus('{0, 16'h7777, 16'hDEAD});
         for (int i = 1; i <= 300 && k == 0; i++) begin
            @(negedge clk);
            if (rsp_vld != '0) k = i;
         end
         checkOutput("timeout_latency", 32'(k), 32'(TO_CYC + 1));
         checkOutput("to_err_set", 32'(to_err), 32'd1);
         slave_en = 1'b1;
         waitSig("drain", 2, 20);
         applyStimulus('{1, 16'h0102, 16'h3E3D});
         waitSig("rsp", 1, 20);
         waitSig("drain", 2, 20);
         checkOutput("to_err_sticky", 32'(to_err), 32'd1);
      end
`endif

      $display("Result: errors=%0d of %0d checks", n_err, n_checks);
      $finish;
   end

   initial begin
      #2000000;
      $display("[TB] FAIL watchdog: simulation did not finish");
      $fatal(1, "[TB] watchdog expired");
   end

endmodule
